conv_out_serializer: RTL and testbench



---
 rtl/conv_out_serializer_if.sv | 23 ++
 rtl/conv_out_serializer.sv | 141 ++++++++++++++
 tb/tb_conv_out_serializer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_out_serializer_if.sv
// Result-stream bus: one convolution output word per beat with its row/column position.
interface conv_out_serializer_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ROW_W  = 2,
    parameter int unsigned COL_W  = 2
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ROW_W-1:0]  m_row;
    logic [COL_W-1:0]  m_col;
    logic              m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/conv_out_serializer.sv
// Captures the flattened convolution result bus in one cycle and streams it out
// row-major, one word per beat, with row/column indices and a last flag.
module conv_out_serializer #(
    parameter int unsigned In_d_W = 8,
    parameter int unsigned R_N    = 5,
    parameter int unsigned C_N    = 5,
    parameter int unsigned R_F    = 3,
    parameter int unsigned C_F    = 3,
    parameter int unsigned P      = 0,
    parameter int unsigned S      = 1,
    localparam int unsigned R_O     = ((R_N + 2*P - R_F) / S) + 1,
    localparam int unsigned C_O     = ((C_N + 2*P - C_F) / S) + 1,
    localparam int unsigned Out_d_W = 2*In_d_W + 2,
    localparam int unsigned N_O     = R_O * C_O,
    localparam int unsigned IDX_W   = (N_O > 1) ? $clog2(N_O) : 1,
    localparam int unsigned ROW_W   = (R_O > 1) ? $clog2(R_O) : 1,
    localparam int unsigned COL_W   = (C_O > 1) ? $clog2(C_O) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     load,
    input  logic [Out_d_W*N_O-1:0]   Y,
    output logic                     load_ready,
    output logic                     done,
    output logic                     load_err,
    conv_out_serializer_if.master    m
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [Out_d_W-1:0] cap_q [N_O];
    logic [Out_d_W-1:0] cap_d [N_O];

    logic               valid_q, valid_d;
    logic [Out_d_W-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic beat;
    logic accept;

    // A load is taken in IDLE or on the final handshake, which allows gapless back-to-back frames.
    assign beat       = valid_q & m.m_ready;
    assign load_ready = (state_q == IDLE) | (beat & last_q);
    assign accept     = load & load_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next state, word index, row/column counters and capture buffer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        cap_d   = cap_q;
        if (accept) begin
            state_d = STREAM;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            for (int t = 0; t < N_O; t++) begin
                cap_d[t] = Y[t*Out_d_W +: Out_d_W];
            end
        end else if (beat) begin
            if (last_q) begin
                state_d = IDLE;
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (col_q == COL_W'(C_O - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Next output values; words are presented from the post-update buffer so word 0 appears one cycle after load
    always_comb begin
        valid_d = (state_d == STREAM);
        data_d  = '0;
        last_d  = 1'b0;
        if (valid_d) begin
            data_d = cap_d[idx_d];
            last_d = (idx_d == IDX_W'(N_O - 1));
        end
        done_d = beat & last_q;
        err_d  = load & ~load_ready;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cap_q   <= '{default: '0};
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (clk_en) begin
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_row   = row_q;
    assign m.m_col   = col_q;
    assign m.m_last  = last_q;
    assign done      = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_conv_out_serializer.sv
// Self-checking bench for conv_out_serializer at default geometry (3x3 outputs, 18-bit words).
module tb_conv_out_serializer;

    localparam int unsigned DW = 18;
    localparam int unsigned NO = 9;
    localparam int unsigned CO = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            load;
    logic [DW*NO-1:0] y;
    logic            load_ready;
    logic            done;
    logic            load_err;

    conv_out_serializer_if #(.DATA_W(DW), .ROW_W(2), .COL_W(2)) sif ();

    conv_out_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .load       (load),
        .Y          (y),
        .load_ready (load_ready),
        .done       (done),
        .load_err   (load_err),
        .m          (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    row;
        logic [1:0]    col;
        logic          last;
    } exp_t;

    typedef struct {
        logic [DW-1:0] base;
        int            ready_mode;
        int            exp_beats;
        int            exp_done;
    } vec_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   beat_cnt  = 0;

    logic          p_ok = 1'b0;
    logic          p_valid, p_beat, p_rst, p_last;
    logic [DW-1:0] p_data;
    logic [1:0]    p_row, p_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_y(input logic [DW-1:0] base);
        for (int t = 0; t < NO; t++) y[t*DW +: DW] = base + DW'(t);
    endtask

    task automatic push_exp(input logic [DW-1:0] base);
        exp_t e;
        for (int t = 0; t < NO; t++) begin
            e.data = base + DW'(t);
            e.row  = 2'(t / CO);
            e.col  = 2'(t % CO);
            e.last = (t == NO - 1);
            sb.push_back(e);
        end
    endtask

    // Observes outputs at the falling edge with the inputs that the next rising edge will see.
    task automatic monitor();
        logic beat;
        exp_t e;
        beat = !rst && clk_en && sif.m_valid && sif.m_ready;
        if (p_ok && p_valid && !p_beat && !p_rst && sif.m_valid)
            check("stall_hold", {sif.m_data, sif.m_row, sif.m_col, sif.m_last},
                  {p_data, p_row, p_col, p_last});
        if (beat) begin
            beat_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h with no word expected at %0t",
                         sif.m_data, $time);
            end else begin
                e = sb.pop_front();
                check("beat_data", sif.m_data, e.data);
                check("beat_pos", {sif.m_row, sif.m_col, sif.m_last}, {e.row, e.col, e.last});
            end
        end
        if (done)     done_cnt++;
        if (load_err) err_cnt++;
        p_ok    = 1'b1;
        p_valid = sif.m_valid;
        p_beat  = beat;
        p_rst   = rst;
        p_data  = sif.m_data;
        p_row   = sif.m_row;
        p_col   = sif.m_col;
        p_last  = sif.m_last;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int mode, input int target_done);
        int cyc = 0;
        while (done_cnt < target_done && cyc < 200) begin
            case (mode)
                1:       sif.m_ready = (cyc % 3 == 0);
                2:       sif.m_ready = 1'($urandom_range(0, 1));
                default: sif.m_ready = 1'b1;
            endcase
            tick();
            cyc++;
        end
        check("stream_timeout", 32'(done_cnt >= target_done), 32'd1);
        sif.m_ready = 1'b1;
    endtask

    task automatic start_load(input logic [DW-1:0] base);
        set_y(base);
        push_exp(base);
        load = 1'b1;
        tick();
        load = 1'b0;
        y = ~y;
    endtask

    task automatic adv_to(input logic [DW-1:0] w);
        int n = 0;
        while (sif.m_data !== w && n < 30) begin
            tick();
            n++;
        end
        check("reach_word", sif.m_data, w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   b0, d0, e0;

        vecs[0] = '{base: 18'h00100, ready_mode: 0, exp_beats: 9, exp_done: 1};
        vecs[1] = '{base: 18'h00100, ready_mode: 1, exp_beats: 9, exp_done: 1};
        vecs[2] = '{base: 18'h00300, ready_mode: 2, exp_beats: 9, exp_done: 1};
        vecs[3] = '{base: 18'h3FFF0, ready_mode: 0, exp_beats: 9, exp_done: 1};

        rst = 1'b1; clk_en = 1'b1; load = 1'b0; y = '0; sif.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", sif.m_valid, 0);
        check("rst_outputs", {sif.m_data, sif.m_row, sif.m_col, sif.m_last}, 0);
        check("rst_pulses", {done, load_err}, 0);
        check("rst_load_ready", load_ready, 1);

        for (int v = 0; v < 4; v++) begin
            b0 = beat_cnt;
            d0 = done_cnt;
            check("idle_load_ready", load_ready, 1);
            sif.m_ready = 1'b1;
            start_load(vecs[v].base);
            check("first_valid", sif.m_valid, 1);
            check("first_data", sif.m_data, vecs[v].base);
            run_stream(vecs[v].ready_mode, d0 + 1);
            check("beats", beat_cnt - b0, vecs[v].exp_beats);
            check("done_pulses", done_cnt - d0, vecs[v].exp_done);
            check("sb_empty", sb.size(), 0);
            check("idle_done_low", done, 0);
            tick();
            check("idle_outputs", {sif.m_valid, sif.m_data, sif.m_row, sif.m_col, sif.m_last}, 0);
        end

        // Back-to-back frames: second load during the final handshake
        d0 = done_cnt;
        sif.m_ready = 1'b1;
        start_load(18'h100);
        adv_to(18'h108);
        check("b2b_last_flag", sif.m_last, 1);
        set_y(18'h200);
        push_exp(18'h200);
        load = 1'b1;
        check("b2b_load_ready", load_ready, 1);
        tick();
        load = 1'b0;
        check("b2b_no_bubble", sif.m_valid, 1);
        check("b2b_first_data", sif.m_data, 18'h200);
        check("b2b_done", done, 1);
        run_stream(0, d0 + 2);
        check("b2b_done_total", done_cnt - d0, 2);
        check("b2b_sb_empty", sb.size(), 0);
        tick();

        // Load while streaming is rejected
        d0 = done_cnt;
        e0 = err_cnt;
        start_load(18'h100);
        adv_to(18'h104);
        set_y(18'h500);
        load = 1'b1;
        check("busy_load_ready", load_ready, 0);
        tick();
        load = 1'b0;
        check("load_err_pulse", load_err, 1);
        check("busy_continue", sif.m_data, 18'h105);
        tick();
        check("load_err_clear", load_err, 0);
        run_stream(0, d0 + 1);
        check("load_err_count", err_cnt - e0, 1);
        check("busy_sb_empty", sb.size(), 0);
        tick();

        // Clock enable freeze mid-stream
        d0 = done_cnt;
        start_load(18'h100);
        adv_to(18'h103);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_data", sif.m_data, 18'h103);
            check("freeze_pos", {sif.m_valid, sif.m_row, sif.m_col}, {1'b1, 2'd1, 2'd0});
        end
        clk_en = 1'b1;
        run_stream(0, d0 + 1);
        check("freeze_sb_empty", sb.size(), 0);
        tick();

        // Reset mid-stream aborts without done
        start_load(18'h100);
        adv_to(18'h105);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("abort_valid", sif.m_valid, 0);
        check("abort_outputs", {sif.m_data, sif.m_row, sif.m_col, sif.m_last}, 0);
        check("abort_done", done, 0);
        d0 = done_cnt;
        tick();
        tick();
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        start_load(18'h600);
        check("restart_data", sif.m_data, 18'h600);
        check("restart_pos", {sif.m_row, sif.m_col}, 0);
        run_stream(0, d0 + 1);
        check("restart_sb_empty", sb.size(), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
